// File: rtl/pattern_seq_detector_pkg.sv
// Shared definitions for the serial pattern detector: size defaults,
// length-field width helper and the per-cycle command decode type.
package pattern_seq_detector_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_SHIFT = 2'd2
  } cmd_e;

endpackage

// File: rtl/pattern_seq_detector_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module sat_counter
  import pattern_seq_detector_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

  always_comb begin
    sat = &count;
  end

endmodule

// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and
// overlap mode, a registered match pulse and a saturating match counter.
module pattern_seq_detector
  import pattern_seq_detector_pkg::*;
#(
  parameter int                 MAX_LEN     = MAX_LEN_DEF,
  parameter int                 CNT_W       = CNT_W_DEF,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_0010),
  parameter int                 DEF_LEN     = 5,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_valid,
  input  logic               sig,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  // Ones in the low l positions: selects the newest l history bits.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;
  logic               match_p1;

  cmd_e               cmd;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_nxt;
  logic               hit;

  // A load always wins over a same-cycle serial bit, which is dropped.
  always_comb begin
    cmd = CMD_IDLE;
    if (cfg_load) begin
      cmd = CMD_LOAD;
    end else if (sig_valid) begin
      cmd = CMD_SHIFT;
    end
  end

  // Stage p0: history/fill as they would be after accepting this bit.
  always_comb begin
    hist_shift = {hist_p0[MAX_LEN-2:0], sig};
    fill_inc   = (fill_p0 >= LEN_MAX) ? LEN_MAX : fill_p0 + LEN_W'(1);
    mask       = len_mask(len_r);
    hit        = (cmd == CMD_SHIFT) && (len_r != '0) && (fill_inc >= len_r) &&
                 ((hist_shift & mask) == (pat_r & mask));
    fill_nxt   = (hit && !ovl_r) ? '0 : fill_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_r    <= DEF_PATTERN;
      len_r    <= clamp_len(LEN_W'(DEF_LEN));
      ovl_r    <= DEF_OVERLAP;
      hist_p0  <= '0;
      fill_p0  <= '0;
      match_p1 <= 1'b0;
    end else begin
      match_p1 <= hit;
      case (cmd)
        CMD_LOAD: begin
          pat_r   <= cfg_pattern;
          len_r   <= clamp_len(cfg_len);
          ovl_r   <= cfg_overlap;
          hist_p0 <= '0;
          fill_p0 <= '0;
        end
        CMD_SHIFT: begin
          hist_p0 <= hist_shift;
          fill_p0 <= fill_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  // Stage p1: registered match pulse; counter updates on the same edge.
  always_comb begin
    match = match_p1;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit),
    .clr  (cnt_clear),
    .count(match_count),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Table-driven bench for pattern_seq_detector: a default-sized instance and a
// 2-bit-counter instance for saturation, with a scoreboard queue of expectations.
module tb_pattern_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_valid, a_sig, a_load, a_ovl, a_clr;
  logic [7:0] a_pat;
  logic [3:0] a_len;
  logic       a_match, a_sat;
  logic [7:0] a_cnt;

  logic       b_rst_n, b_valid, b_sig, b_load, b_ovl, b_clr;
  logic [7:0] b_pat;
  logic [3:0] b_len;
  logic       b_match, b_sat;
  logic [1:0] b_cnt;

  pattern_seq_detector dut_a (
    .clk(clk), .rst_n(a_rst_n), .sig_valid(a_valid), .sig(a_sig),
    .cfg_load(a_load), .cfg_pattern(a_pat), .cfg_len(a_len),
    .cfg_overlap(a_ovl), .cnt_clear(a_clr), .match(a_match),
    .match_count(a_cnt), .cnt_sat(a_sat)
  );

  pattern_seq_detector #(
    .CNT_W(2), .DEF_PATTERN(8'b0000_0001), .DEF_LEN(1), .DEF_OVERLAP(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .sig_valid(b_valid), .sig(b_sig),
    .cfg_load(b_load), .cfg_pattern(b_pat), .cfg_len(b_len),
    .cfg_overlap(b_ovl), .cnt_clear(b_clr), .match(b_match),
    .match_count(b_cnt), .cnt_sat(b_sat)
  );

  typedef struct {
    bit         rst_n, load, valid, sig, clr;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ovl;
    bit         em;
    int         ec;
    bit         es;
  } vec_t;

  typedef struct {
    bit m;
    int c;
    bit s;
    int idx;
  } exp_t;

  vec_t va[$];
  vec_t vb[$];
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  logic [7:0] cp;
  logic [3:0] cl;
  bit         co;
  int         cc;

  function automatic vec_t mk(bit r, bit ld, bit v, bit s, bit c, bit em, int ec, bit es);
    vec_t x;
    x.rst_n = r; x.load = ld; x.valid = v; x.sig = s; x.clr = c;
    x.pat = cp; x.len = cl; x.ovl = co;
    x.em = em; x.ec = ec; x.es = es;
    return x;
  endfunction

  function automatic void a_feed(bit s, bit em);
    if (em) cc++;
    va.push_back(mk(1, 0, 1, s, 0, em, cc, 0));
  endfunction

  function automatic void a_idle();
    va.push_back(mk(1, 0, 0, 1'b1, 0, 0, cc, 0));
  endfunction

  // Reset with load, valid and sig all high: reset must win over all of them.
  function automatic void a_rst();
    cc = 0;
    va.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
  endfunction

  function automatic void a_cfg(logic [7:0] p, logic [3:0] l, bit o, bit s);
    cp = p; cl = l; co = o;
    va.push_back(mk(1, 1, 1, s, 0, 0, cc, 0));
  endfunction

  function automatic void a_clear();
    cc = 0;
    va.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply_a(input vec_t v, input int idx);
    exp_t e;
    a_rst_n = v.rst_n; a_load = v.load; a_valid = v.valid; a_sig = v.sig;
    a_clr = v.clr; a_pat = v.pat; a_len = v.len; a_ovl = v.ovl;
    sbq.push_back('{v.em, v.ec, v.es, idx});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("a_match", e.idx, 32'(a_match), 32'(e.m));
    chk("a_count", e.idx, 32'(a_cnt), 32'(e.c));
    chk("a_sat", e.idx, 32'(a_sat), 32'(e.s));
  endtask

  task automatic apply_b(input vec_t v, input int idx);
    exp_t e;
    b_rst_n = v.rst_n; b_load = v.load; b_valid = v.valid; b_sig = v.sig;
    b_clr = v.clr; b_pat = v.pat; b_len = v.len; b_ovl = v.ovl;
    sbq.push_back('{v.em, v.ec, v.es, idx});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("b_match", e.idx, 32'(b_match), 32'(e.m));
    chk("b_count", e.idx, 32'(b_cnt), 32'(e.c));
    chk("b_sat", e.idx, 32'(b_sat), 32'(e.s));
  endtask

  initial begin
    a_rst_n = 1'b0; a_valid = 1'b0; a_sig = 1'b0; a_load = 1'b0; a_ovl = 1'b0;
    a_clr = 1'b0; a_pat = '0; a_len = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_sig = 1'b0; b_load = 1'b0; b_ovl = 1'b0;
    b_clr = 1'b0; b_pat = '0; b_len = '0;

    cp = 8'h12; cl = 4'd5; co = 1'b1; cc = 0;

    // Defaults (10010, overlap): matches after bits 5 and 8.
    a_rst();
    a_feed(1, 0); a_feed(0, 0); a_feed(0, 0); a_feed(1, 0); a_feed(0, 1);
    a_feed(0, 0); a_feed(1, 0); a_feed(0, 1);
    a_clear();

    // Stall in the middle of a pattern.
    a_rst();
    a_feed(1, 0); a_feed(0, 0);
    a_idle(); a_idle(); a_idle(); a_idle();
    a_feed(0, 0); a_feed(1, 0); a_feed(0, 1);

    // Reset in the middle of a pattern.
    a_rst();
    a_feed(1, 0); a_feed(0, 0); a_feed(0, 0); a_feed(1, 0);
    a_rst();
    a_feed(0, 0);

    // Load in the middle of a pattern; the same-cycle sig=1 is dropped.
    a_feed(1, 0); a_feed(0, 0); a_feed(0, 0);
    a_cfg(8'b1111_0101, 4'd3, 1'b1, 1'b1);
    a_feed(0, 0); a_feed(1, 0); a_feed(0, 0); a_feed(1, 1);

    // 101 non-overlapping, then overlapping.
    a_cfg(8'b0000_0101, 4'd3, 1'b0, 1'b0);
    a_feed(1, 0); a_feed(0, 0); a_feed(1, 1); a_feed(0, 0); a_feed(1, 0);
    a_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
    a_feed(1, 0); a_feed(0, 0); a_feed(1, 1); a_feed(0, 0); a_feed(1, 1);

    // Length zero never matches.
    a_cfg(8'($urandom), 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) a_feed(1'($urandom_range(0, 1)), 0);

    // Length above MAX_LEN clamps to MAX_LEN.
    a_cfg(8'b1011_0011, 4'd11, 1'b0, 1'b0);
    a_feed(1, 0); a_feed(0, 0); a_feed(1, 0); a_feed(1, 0);
    a_feed(0, 0); a_feed(0, 0); a_feed(1, 0); a_feed(1, 1);
    a_feed(1, 0);

    // Counter saturation and clear priority on the 2-bit instance.
    vb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 1, 0));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 2, 0));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 3, 1));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 3, 1));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 3, 1));
    vb.push_back(mk(1, 0, 1, 0, 0, 0, 3, 1));
    vb.push_back(mk(1, 0, 0, 1, 0, 0, 3, 1));
    vb.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0));
    vb.push_back(mk(1, 0, 1, 1, 0, 1, 1, 0));
    vb.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vb.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));

    for (int i = 0; i < va.size(); i++) apply_a(va[i], i);
    a_valid = 1'b0; a_load = 1'b0; a_clr = 1'b0;
    for (int i = 0; i < vb.size(); i++) apply_b(vb[i], 1000 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
